// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WCNT_W = 8;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Control bundle driven to the stage registers.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
        logic pipe_freeze;
        logic mem_wb_bubble;
    } stage_ctrl_t;

    // Normal advance: PC and IF/ID load, nothing squashed.
    localparam stage_ctrl_t CTRL_RUN     = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    // Memory wait: front end held, ID/EX and EX/MEM frozen, MEM/WB fed a bubble.
    localparam stage_ctrl_t CTRL_FREEZE  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    // Completion cycle: back end advances, front end still held.
    localparam stage_ctrl_t CTRL_RELEASE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    // Reset: everything squashed, nothing advances.
    localparam stage_ctrl_t CTRL_RESET   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: a load in ID/EX feeding a source of the IF/ID instruction.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    output logic             lu
);

    // r0 is hardwired zero, so a load targeting it never creates a dependency.
    always_comb begin
        lu = id_ex_mem_read
             && (id_ex_rt != REG_ZERO)
             && ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers.
// Optional feature macro: PIPE_PERF_CNT_EN enables the performance counters;
// when undefined the counter ports are tied to zero.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] if_id_rs,
    input  logic [REG_W-1:0] if_id_rt,
    input  logic             id_ex_mem_read,
    input  logic [REG_W-1:0] id_ex_rt,
    input  logic             branch_taken,
    input  logic             ex_mem_mem_read,
    input  logic             ex_mem_mem_write,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             pipe_freeze,
    output logic             mem_wb_bubble,
    output logic             mem_err,
    output logic [CNT_W-1:0] perf_lu_stalls,
    output logic [CNT_W-1:0] perf_mem_waits,
    output logic [CNT_W-1:0] perf_flushes
);

    localparam logic [WCNT_W-1:0] TIMEOUT = WCNT_W'(MEM_TIMEOUT);

    state_t            state;
    state_t            state_nxt;
    logic [WCNT_W-1:0] wait_cnt;
    logic [WCNT_W-1:0] wait_cnt_nxt;
    logic              mem_err_q;
    logic              mem_err_nxt;
    logic              lu;
    logic              mem_access;
    stage_ctrl_t       ctrl;

    load_use_detect u_lu (
        .if_id_rs       (if_id_rs),
        .if_id_rt       (if_id_rt),
        .id_ex_mem_read (id_ex_mem_read),
        .id_ex_rt       (id_ex_rt),
        .lu             (lu)
    );

    assign mem_access = ex_mem_mem_read | ex_mem_mem_write;

    // Next-state and control decode; memory freeze outranks load-use, which outranks branch flush.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        mem_err_nxt  = mem_err_q;
        ctrl         = CTRL_RUN;

        case (state)
            RUN: begin
                if (mem_access && !dmem_ready) begin
                    state_nxt    = MEM_WAIT;
                    wait_cnt_nxt = WCNT_W'(1);
                    ctrl         = CTRL_FREEZE;
                end else if (lu) begin
                    ctrl.pc_write     = 1'b0;
                    ctrl.if_id_write  = 1'b0;
                    ctrl.id_ex_bubble = 1'b1;
                end else if (branch_taken) begin
                    ctrl.if_id_flush = 1'b1;
                end
            end
            MEM_WAIT: begin
                ctrl = CTRL_FREEZE;
                if (dmem_ready) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    ctrl         = CTRL_RELEASE;
                end else if (wait_cnt >= TIMEOUT) begin
                    state_nxt    = RUN;
                    wait_cnt_nxt = '0;
                    mem_err_nxt  = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + WCNT_W'(1);
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if (rst) begin
            ctrl = CTRL_RESET;
        end
    end

    // State, wait counter and sticky error register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            wait_cnt  <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state     <= state_nxt;
            wait_cnt  <= wait_cnt_nxt;
            mem_err_q <= mem_err_nxt;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_bubble  = ctrl.id_ex_bubble;
    assign pipe_freeze   = ctrl.pipe_freeze;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign mem_err       = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic lu_stall_c;

    assign lu_stall_c = (state == RUN) && lu && !ctrl.pipe_freeze && !rst;

    // Event counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_stalls <= '0;
            perf_mem_waits <= '0;
            perf_flushes   <= '0;
        end else begin
            if (lu_stall_c) begin
                perf_lu_stalls <= perf_lu_stalls + CNT_W'(1);
            end
            if (ctrl.pipe_freeze) begin
                perf_mem_waits <= perf_mem_waits + CNT_W'(1);
            end
            if (ctrl.if_id_flush) begin
                perf_flushes <= perf_flushes + CNT_W'(1);
            end
        end
    end
`else
    assign perf_lu_stalls = '0;
    assign perf_mem_waits = '0;
    assign perf_flushes   = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4).
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W = 32;
`ifdef PIPE_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // ctrl vector order: pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_wb_bubble
    localparam logic [5:0] C_RUN     = 6'b110000;
    localparam logic [5:0] C_LU      = 6'b000100;
    localparam logic [5:0] C_FLUSH   = 6'b111000;
    localparam logic [5:0] C_FREEZE  = 6'b000011;
    localparam logic [5:0] C_RELEASE = 6'b000000;
    localparam logic [5:0] C_RESET   = 6'b001101;

    logic             clk = 1'b0;
    logic             rst;
    logic [4:0]       if_id_rs, if_id_rt, id_ex_rt;
    logic             id_ex_mem_read, branch_taken;
    logic             ex_mem_mem_read, ex_mem_mem_write, dmem_ready;
    logic             pc_write, if_id_write, if_id_flush, id_ex_bubble;
    logic             pipe_freeze, mem_wb_bubble, mem_err;
    logic [CNT_W-1:0] perf_lu_stalls, perf_mem_waits, perf_flushes;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [4:0] rs;
        logic [4:0] rt;
        logic       ld;
        logic [4:0] ld_rt;
        logic       br;
        logic       mrd;
        logic       mwr;
        logic       rdy;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[11];

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .if_id_rs         (if_id_rs),
        .if_id_rt         (if_id_rt),
        .id_ex_mem_read   (id_ex_mem_read),
        .id_ex_rt         (id_ex_rt),
        .branch_taken     (branch_taken),
        .ex_mem_mem_read  (ex_mem_mem_read),
        .ex_mem_mem_write (ex_mem_mem_write),
        .dmem_ready       (dmem_ready),
        .pc_write         (pc_write),
        .if_id_write      (if_id_write),
        .if_id_flush      (if_id_flush),
        .id_ex_bubble     (id_ex_bubble),
        .pipe_freeze      (pipe_freeze),
        .mem_wb_bubble    (mem_wb_bubble),
        .mem_err          (mem_err),
        .perf_lu_stalls   (perf_lu_stalls),
        .perf_mem_waits   (perf_mem_waits),
        .perf_flushes     (perf_flushes)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    task automatic apply(input vec_t v);
        if_id_rs         = v.rs;
        if_id_rt         = v.rt;
        id_ex_mem_read   = v.ld;
        id_ex_rt         = v.ld_rt;
        branch_taken     = v.br;
        ex_mem_mem_read  = v.mrd;
        ex_mem_mem_write = v.mwr;
        dmem_ready       = v.rdy;
    endtask

    task automatic set_mem(input logic mrd, input logic rdy);
        ex_mem_mem_read = mrd;
        dmem_ready      = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ctrl(input string name, input logic [5:0] exp);
        logic [5:0] act;
        @(negedge clk);
        act = {pc_write, if_id_write, if_id_flush, id_ex_bubble, pipe_freeze, mem_wb_bubble};
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: ctrl got %b want %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic check_perf(input string tag, input int lu_n, input int mw_n, input int fl_n);
        check_val({tag, "_lu"}, perf_lu_stalls, PERF ? CNT_W'(lu_n) : '0);
        check_val({tag, "_mw"}, perf_mem_waits, PERF ? CNT_W'(mw_n) : '0);
        check_val({tag, "_fl"}, perf_flushes,   PERF ? CNT_W'(fl_n) : '0);
    endtask

    initial begin
        //            rs     rt     ld    ld_rt  br    mrd   mwr   rdy   exp
        vecs[0]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[1]  = '{5'd5, 5'd1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[2]  = '{5'd2, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[3]  = '{5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[4]  = '{5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[5]  = '{5'd6, 5'd4, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_RUN};
        vecs[6]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_FLUSH};
        vecs[7]  = '{5'd9, 5'd3, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LU};
        vecs[8]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, C_RUN};
        vecs[9]  = '{5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, C_FLUSH};
        vecs[10] = '{5'd31, 5'd2, 1'b1, 5'd31, 1'b0, 1'b1, 1'b0, 1'b1, C_LU};

        // Reset: a would-be memory stall must not override the reset controls
        apply(vecs[0]);
        set_mem(1'b1, 1'b0);
        rst = 1'b1;
        check_ctrl("rst_c1", C_RESET);
        tick();
        check_ctrl("rst_c2", C_RESET);
        tick();
        rst = 1'b0;
        set_mem(1'b0, 1'b0);
        check_ctrl("post_rst", C_RUN);
        check_val("post_rst_err", 32'(mem_err), 32'd0);
        check_perf("post_rst", 0, 0, 0);
        tick();

        // Single-cycle combinational vectors in RUN
        for (int i = 0; i < 11; i++) begin
            apply(vecs[i]);
            check_ctrl($sformatf("vec%0d", i), vecs[i].exp);
            tick();
        end
        apply(vecs[0]);

        // Load-use with branch: branch held, then flushed once the hazard clears
        apply(vecs[7]);
        check_ctrl("lu_br_hold", C_LU);
        tick();
        id_ex_mem_read = 1'b0;
        check_ctrl("lu_br_flush", C_FLUSH);
        tick();
        apply(vecs[0]);
        check_perf("after_table", 5, 0, 3);

        // Multi-cycle memory access: three frozen cycles then release
        set_mem(1'b1, 1'b0);
        id_ex_mem_read = 1'b1; id_ex_rt = 5'd4; if_id_rs = 5'd4;
        check_ctrl("mw_enter", C_FREEZE);
        tick();
        check_ctrl("mw_w1", C_FREEZE);
        tick();
        check_ctrl("mw_w2", C_FREEZE);
        tick();
        dmem_ready = 1'b1;
        check_ctrl("mw_ready", C_RELEASE);
        tick();
        apply(vecs[0]);
        check_ctrl("mw_resume", C_RUN);
        check_val("mw_err", 32'(mem_err), 32'd0);
        check_perf("after_mw", 5, 3, 3);
        tick();

        // Timeout: four wait cycles after entry, then back to RUN with sticky error
        set_mem(1'b1, 1'b0);
        check_ctrl("to_enter", C_FREEZE);
        tick();
        for (int w = 1; w <= 4; w++) begin
            check_ctrl($sformatf("to_w%0d", w), C_FREEZE);
            check_val($sformatf("to_err_w%0d", w), 32'(mem_err), 32'd0);
            tick();
        end
        set_mem(1'b0, 1'b0);
        check_ctrl("to_run", C_RUN);
        check_val("to_err_set", 32'(mem_err), 32'd1);
        tick();
        set_mem(1'b1, 1'b1);
        check_ctrl("to_single", C_RUN);
        tick();
        set_mem(1'b0, 1'b0);
        check_val("to_err_sticky", 32'(mem_err), 32'd1);
        check_perf("after_to", 5, 8, 3);

        // Reset during the second wait cycle aborts the access
        set_mem(1'b1, 1'b0);
        check_ctrl("rw_enter", C_FREEZE);
        tick();
        check_ctrl("rw_w1", C_FREEZE);
        tick();
        rst = 1'b1;
        check_ctrl("rw_rst", C_RESET);
        tick();
        rst = 1'b0;
        set_mem(1'b0, 1'b0);
        check_ctrl("rw_run", C_RUN);
        check_val("rw_err_clr", 32'(mem_err), 32'd0);
        check_perf("rw", 0, 0, 0);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
